// File: rtl/sysctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sysctrl_pkg                                            |
// | Description : Shared system-control definitions: arbiter FSM state   |
// |               encoding, port count, idle-counter width and default   |
// |               hold / timeout cycle counts.                           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package sysctrl_pkg;

  localparam int NUM_PORTS       = 4;
  localparam int CNT_W           = 12;
  localparam int HOLD_CYC_DEF    = 16;
  localparam int TIMEOUT_CYC_DEF = 4095;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    BUSY = 2'd2
  } arb_state_e;

endpackage : sysctrl_pkg
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rr_pick4                                               |
// | Description : Four-way round-robin picker. Searches the request      |
// |               vector starting at last_grant+1 (mod 4); last_grant    |
// |               itself is the final candidate.                         |
// | Ports       : req        - request vector, one bit per port          |
// |               last_grant - index granted most recently               |
// |               next_idx   - first requesting index found              |
// |               found      - high when any request is set              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] next_idx,
  output logic       found
);

  always_comb begin
    logic [1:0] w_idx;
    found    = 1'b0;
    next_idx = last_grant;
    w_idx    = last_grant;
    for (int i = 1; i <= 4; i++) begin
      w_idx = last_grant + 2'(i);
      if (!found && req[w_idx]) begin
        found    = 1'b1;
        next_idx = w_idx;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : port_arbiter                                           |
// | Description : Shares one MCU byte interface between four ports.      |
// |               IDLE -> ARB (one cycle, round-robin pick) -> BUSY.     |
// |               BUSY is held while strobes keep coming; it is released |
// |               after HOLD_CYC quiet cycles once the granted port is   |
// |               empty, or after TIMEOUT_CYC quiet cycles regardless.   |
// | Ports       : clk, reset_n           - clock, async active-low reset |
// |               up_*                   - MCU-side view of granted port |
// |               p_*                    - packed per-port fields        |
// |               grant, busy            - current grant index, BUSY     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module port_arbiter
  import sysctrl_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [7:0]   up_out_available,
  input  logic         up_out_strobe,
  output logic [7:0]   up_out_data,
  output logic [7:0]   up_in_available,
  input  logic         up_in_strobe,
  input  logic [7:0]   up_in_data,
  output logic [31:0]  up_status,
  input  logic [31:0]  p_out_available,
  input  logic [31:0]  p_out_data,
  input  logic [31:0]  p_in_available,
  input  logic [127:0] p_status,
  output logic [3:0]   p_out_strobe,
  output logic [3:0]   p_in_strobe,
  output logic [7:0]   p_in_data,
  output logic [1:0]   grant,
  output logic         busy
);

  localparam logic [CNT_W-1:0] c_hold_cnt    = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] c_timeout_cnt = CNT_W'(TIMEOUT_CYC);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  logic [3:0]       w_req;
  logic [1:0]       w_rr_idx;
  logic             w_rr_found;
  logic             w_strobe_any;

  always_comb begin
    w_req = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_req[k] = |p_out_available[k*8 +: 8];
    end
  end

  assign w_strobe_any = up_out_strobe | up_in_strobe;

  rr_pick4 u_rr_pick4 (
    .req        (w_req),
    .last_grant (grant_q),
    .next_idx   (w_rr_idx),
    .found      (w_rr_found)
  );

  // Next-state, grant and idle counter
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|w_req) state_d = ARB;
      end
      ARB: begin
        if (w_rr_found) begin
          state_d    = BUSY;
          grant_d    = w_rr_idx;
          idle_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        // A strobe always wins over any exit: the transfer is still live.
        // The timeout check precedes the hold check so it wins a tie.
        if (w_strobe_any) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q >= c_timeout_cnt) begin
          state_d = ARB;
        end else if (!w_req[grant_q] && (idle_cnt_q >= c_hold_cnt)) begin
          state_d = IDLE;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (w_strobe_any) idle_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'd0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // MCU-side view of the granted port. out_available is forced to zero in
  // ARB so the MCU control block sees a fresh rising edge after a switch.
  always_comb begin
    up_out_available = p_out_available[{grant_q, 3'b000} +: 8];
    if (state_q == ARB) up_out_available = 8'd0;
    up_out_data     = p_out_data[{grant_q, 3'b000} +: 8];
    up_in_available = p_in_available[{grant_q, 3'b000} +: 8];
    up_status       = p_status[{grant_q, 5'b00000} +: 32];
  end

  // Strobes follow the current grant in every state, ARB included.
  always_comb begin
    p_out_strobe          = 4'b0000;
    p_in_strobe           = 4'b0000;
    p_out_strobe[grant_q] = up_out_strobe;
    p_in_strobe[grant_q]  = up_in_strobe;
  end

  assign p_in_data = up_in_data;
  assign grant     = grant_q;
  assign busy      = (state_q == BUSY);

endmodule : port_arbiter
`default_nettype wire

// File: tb/tb_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_port_arbiter                                        |
// | Description : Self-checking bench for port_arbiter.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_port_arbiter;

  logic         clk;
  logic         reset_n;
  logic [7:0]   up_out_available;
  logic         up_out_strobe;
  logic [7:0]   up_out_data;
  logic [7:0]   up_in_available;
  logic         up_in_strobe;
  logic [7:0]   up_in_data;
  logic [31:0]  up_status;
  logic [31:0]  p_out_available;
  logic [31:0]  p_out_data;
  logic [31:0]  p_in_available;
  logic [127:0] p_status;
  logic [3:0]   p_out_strobe;
  logic [3:0]   p_in_strobe;
  logic [7:0]   p_in_data;
  logic [1:0]   grant;
  logic         busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] pos;
    logic [3:0] pis;
    logic [7:0] pid;
  } exp_t;

  typedef struct {
    logic       os;
    logic       is;
    logic [7:0] d;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vec[4];

  port_arbiter #(.HOLD_CYC(16), .TIMEOUT_CYC(4095)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .up_out_available (up_out_available),
    .up_out_strobe    (up_out_strobe),
    .up_out_data      (up_out_data),
    .up_in_available  (up_in_available),
    .up_in_strobe     (up_in_strobe),
    .up_in_data       (up_in_data),
    .up_status        (up_status),
    .p_out_available  (p_out_available),
    .p_out_data       (p_out_data),
    .p_in_available   (p_in_available),
    .p_status         (p_status),
    .p_out_strobe     (p_out_strobe),
    .p_in_strobe      (p_in_strobe),
    .p_in_data        (p_in_data),
    .grant            (grant),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_avail(input int k, input logic [7:0] v);
    p_out_available[k*8 +: 8] = v;
  endtask

  // One out-strobe to port k; the port's byte count drops after the edge.
  task automatic strobe_out(input int k, input string nm);
    logic [3:0] w_exp;
    w_exp    = 4'b0000;
    w_exp[k] = 1'b1;
    up_out_strobe = 1'b1;
    #1;
    check(nm, {28'd0, p_out_strobe}, {28'd0, w_exp});
    tick();
    up_out_strobe = 1'b0;
    set_avail(k, p_out_available[k*8 +: 8] - 8'd1);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string nm);
    int n = 0;
    while (busy !== val && n < budget) begin
      tick();
      n++;
    end
    check(nm, {31'd0, busy}, {31'd0, val});
  endtask

  initial begin
    exp_t e;
    reset_n         = 1'b0;
    up_out_strobe   = 1'b0;
    up_in_strobe    = 1'b0;
    up_in_data      = 8'h00;
    p_out_available = 32'd0;
    p_out_data      = 32'hD3D2_D1D0;
    p_in_available  = 32'h1312_1110;
    p_status        = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};

    vec[0] = '{1'b0, 1'b1, 8'h41, '{4'b0000, 4'b1000, 8'h41}};
    vec[1] = '{1'b1, 1'b0, 8'h00, '{4'b1000, 4'b0000, 8'h00}};
    vec[2] = '{1'b1, 1'b1, 8'hFF, '{4'b1000, 4'b1000, 8'hFF}};
    vec[3] = '{1'b0, 1'b0, 8'h5A, '{4'b0000, 4'b0000, 8'h5A}};

    // Reset state
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_status", up_status, 32'hA0A0_0000);
    check("rst_in_avail", {24'd0, up_in_available}, 32'h10);
    check("rst_out_data", {24'd0, up_out_data}, 32'hD0);
    up_out_strobe = 1'b1;
    #1;
    check("rst_strobe_route", {28'd0, p_out_strobe}, 32'h1);
    up_out_strobe = 1'b0;
    #10;
    reset_n = 1'b1;
    tick();

    // Single requester on port 2
    set_avail(2, 8'd5);
    tick();
    check("arb_busy", {31'd0, busy}, 32'd0);
    check("arb_out_avail_zero", {24'd0, up_out_available}, 32'd0);
    check("arb_grant_parked", {30'd0, grant}, 32'd0);
    tick();
    check("p2_grant", {30'd0, grant}, 32'd2);
    check("p2_out_avail", {24'd0, up_out_available}, 32'd5);
    check("p2_busy", {31'd0, busy}, 32'd1);

    // Drain port 2, then the hold period
    for (int i = 0; i < 5; i++) strobe_out(2, "p2_strobe_route");
    repeat (16) tick();
    check("hold_still_busy", {31'd0, busy}, 32'd1);
    tick();
    check("hold_released", {31'd0, busy}, 32'd0);
    check("hold_grant_parked", {30'd0, grant}, 32'd2);

    // Round-robin 1 -> 3 -> 0
    set_avail(1, 8'd1);
    wait_busy(1'b1, 5, "rr_p1_busy");
    check("rr_grant1", {30'd0, grant}, 32'd1);
    set_avail(0, 8'd2);
    set_avail(3, 8'd3);
    strobe_out(1, "rr_p1_strobe");
    wait_busy(1'b0, 40, "rr_p1_release");
    wait_busy(1'b1, 5, "rr_p3_busy");
    check("rr_grant3", {30'd0, grant}, 32'd3);
    for (int i = 0; i < 3; i++) strobe_out(3, "rr_p3_strobe");
    wait_busy(1'b0, 40, "rr_p3_release");
    wait_busy(1'b1, 5, "rr_p0_busy");
    check("rr_grant0", {30'd0, grant}, 32'd0);
    for (int i = 0; i < 2; i++) strobe_out(0, "rr_p0_strobe");
    wait_busy(1'b0, 40, "rr_p0_release");

    // Starvation timeout with a single requester
    set_avail(0, 8'd10);
    wait_busy(1'b1, 5, "to_busy");
    check("to_grant", {30'd0, grant}, 32'd0);
    repeat (4095) tick();
    check("to_before_busy", {31'd0, busy}, 32'd1);
    check("to_before_avail", {24'd0, up_out_available}, 32'd10);
    tick();
    check("to_arb_busy", {31'd0, busy}, 32'd0);
    check("to_arb_avail_dip", {24'd0, up_out_available}, 32'd0);
    tick();
    check("to_regrant_busy", {31'd0, busy}, 32'd1);
    check("to_regrant_grant", {30'd0, grant}, 32'd0);
    check("to_regrant_avail", {24'd0, up_out_available}, 32'd10);

    // Move grant to port 3, then the strobe routing table
    set_avail(0, 8'd0);
    set_avail(3, 8'd1);
    wait_busy(1'b0, 40, "p3_release0");
    wait_busy(1'b1, 5, "p3_busy");
    check("p3_grant", {30'd0, grant}, 32'd3);
    check("p3_status", up_status, 32'hA0A0_0003);
    check("p3_in_avail", {24'd0, up_in_available}, 32'h13);
    check("p3_out_data", {24'd0, up_out_data}, 32'hD3);
    for (int i = 0; i < 4; i++) begin
      up_out_strobe = vec[i].os;
      up_in_strobe  = vec[i].is;
      up_in_data    = vec[i].d;
      sb_q.push_back(vec[i].e);
      #1;
      e = sb_q.pop_front();
      check("tbl_p_out_strobe", {28'd0, p_out_strobe}, {28'd0, e.pos});
      check("tbl_p_in_strobe", {28'd0, p_in_strobe}, {28'd0, e.pis});
      check("tbl_p_in_data", {24'd0, p_in_data}, {24'd0, e.pid});
      up_out_strobe = 1'b0;
      up_in_strobe  = 1'b0;
    end

    // Strobe coincident with the hold exit keeps BUSY and restarts the count
    set_avail(3, 8'd0);
    repeat (16) tick();
    up_in_strobe = 1'b1;
    tick();
    up_in_strobe = 1'b0;
    check("strobe_blocks_exit", {31'd0, busy}, 32'd1);
    repeat (16) tick();
    check("strobe_hold_busy", {31'd0, busy}, 32'd1);
    tick();
    check("strobe_hold_release", {31'd0, busy}, 32'd0);

    // Reset in the middle of BUSY
    set_avail(2, 8'd3);
    wait_busy(1'b1, 5, "mid_busy");
    check("mid_grant2", {30'd0, grant}, 32'd2);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_grant", {30'd0, grant}, 32'd0);
    check("mid_rst_out_data", {24'd0, up_out_data}, 32'hD0);
    check("mid_rst_no_strobe", {28'd0, p_out_strobe}, 32'd0);
    #10;
    reset_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_port_arbiter
`default_nettype wire
